// File: rtl/raiz_sched.sv
// raiz_sched -- round-robin bus master that shares one memory-mapped
// square-root peripheral (raiz) between N_REQ requesters.
//
// For each granted request it runs the full register sequence on the
// peripheral slave port: write radicand, pulse init (1 then 0), poll the
// done register, read R, read Q. It then returns the results with a
// one-cycle ack to the requester that was granted.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req[N_REQ]      level requests, held until ack
//   radicand        requester i radicand at bits [16i+15:16i]
//   ack[N_REQ]      one-cycle completion pulse to the granted requester
//   err             timeout flag, valid with ack
//   q_out, r_out    root / remainder, valid with ack, held until next ack
//   busy            high from grant through the ACK cycle
//   gnt_id          index of the current/last granted requester
//   per_*           peripheral slave port (cs/rd/wr/addr/d_in/d_out)
module raiz_sched #(
    parameter int          N_REQ     = 2,
    parameter logic [4:0]  ADDR_RR   = 5'h04,
    parameter logic [4:0]  ADDR_INIT = 5'h08,
    parameter logic [4:0]  ADDR_R    = 5'h0C,
    parameter logic [4:0]  ADDR_Q    = 5'h10,
    parameter logic [4:0]  ADDR_DONE = 5'h14,
    parameter logic [15:0] POLL_MAX  = 16'd255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  radicand,
    output logic [N_REQ-1:0]     ack,
    output logic                 err,
    output logic [15:0]          q_out,
    output logic [15:0]          r_out,
    output logic                 busy,
    output logic [1:0]           gnt_id,
    output logic                 per_cs,
    output logic                 per_rd,
    output logic                 per_wr,
    output logic [4:0]           per_addr,
    output logic [15:0]          per_d_in,
    input  logic [15:0]          per_d_out
);

    typedef enum logic [3:0] {
        IDLE, WR_RR, WR_INIT1, WR_INIT0, POLL_RD, POLL_CAP,
        RD_R, R_CAP, RD_Q, Q_CAP, ACK
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         ptr_reg, ptr_next;
    logic [15:0]        rad_reg, rad_next;
    logic [15:0]        poll_reg, poll_next;
    logic [15:0]        r_res_reg, r_res_next;
    logic [1:0]         gnt_id_reg, gnt_id_next;
    logic               busy_reg, busy_next;
    logic [N_REQ-1:0]   ack_reg, ack_next;
    logic               err_reg, err_next;
    logic [15:0]        q_out_reg, q_out_next;
    logic [15:0]        r_out_reg, r_out_next;
    logic               cs_reg, cs_next;
    logic               rd_reg, rd_next;
    logic               wr_reg, wr_next;
    logic [4:0]         addr_reg, addr_next;
    logic [15:0]        d_in_reg, d_in_next;

    // ------------------------------------------------------------------
    // Round-robin search. The request vector is rotated so that bit 0 is
    // the requester after the last granted one; a find-first-set on the
    // rotated vector gives the offset of the winner from that start.
    // ------------------------------------------------------------------
    logic [2:0]         shamt;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   first;
    logic [N_REQ-1:0]   pos0_mask;
    logic [N_REQ-1:0]   pos1_mask;
    logic [1:0]         pos;
    logic [2:0]         sum;
    logic               grant_found;
    logic [1:0]         grant_idx;
    logic [15:0]        rad_sel;

    assign shamt = {1'b0, ptr_reg} + 3'd1;
    assign rot   = N_REQ'({req, req} >> shamt);

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ffs
            if (gi == 0) begin : g_lsb
                assign first[gi] = rot[gi];
            end else begin : g_upper
                assign first[gi] = rot[gi] & ~(|rot[gi-1:0]);
            end
            // Static masks used to binary-encode the one-hot winner.
            assign pos0_mask[gi] = ((gi % 2) == 1);
            assign pos1_mask[gi] = (((gi / 2) % 2) == 1);
        end
    endgenerate

    assign pos         = {|(first & pos1_mask), |(first & pos0_mask)};
    assign grant_found = |rot;
    // shamt + pos is always below 2*N_REQ, so one wrap is enough.
    assign sum         = shamt + {1'b0, pos};
    assign grant_idx   = (sum >= 3'(N_REQ)) ? 2'(sum - 3'(N_REQ)) : 2'(sum);
    assign rad_sel     = 16'(radicand >> {grant_idx, 4'b0000});

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Every output is a register whose
    // next value is derived from the state being entered, so the bus
    // strobes line up with the state they belong to.
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        rad_next    = rad_reg;
        poll_next   = poll_reg;
        r_res_next  = r_res_reg;
        gnt_id_next = gnt_id_reg;
        busy_next   = busy_reg;
        ack_next    = '0;
        err_next    = err_reg;
        q_out_next  = q_out_reg;
        r_out_next  = r_out_reg;
        cs_next     = 1'b0;
        rd_next     = 1'b0;
        wr_next     = 1'b0;
        addr_next   = 5'h00;
        d_in_next   = 16'h0000;

        unique case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    rad_next    = rad_sel;
                    gnt_id_next = grant_idx;
                    busy_next   = 1'b1;
                    poll_next   = 16'd0;
                    state_next  = WR_RR;
                end
            end
            WR_RR:    state_next = WR_INIT1;
            WR_INIT1: state_next = WR_INIT0;
            WR_INIT0: state_next = POLL_RD;
            POLL_RD: begin
                poll_next  = poll_reg + 16'd1;
                state_next = POLL_CAP;
            end
            POLL_CAP: begin
                if (per_d_out[0]) begin
                    state_next = RD_R;
                end else if (poll_reg == POLL_MAX) begin
                    err_next   = 1'b1;
                    q_out_next = 16'hFFFF;
                    r_out_next = 16'hFFFF;
                    state_next = ACK;
                end else begin
                    state_next = POLL_RD;
                end
            end
            RD_R:  state_next = R_CAP;
            R_CAP: begin
                // Held privately so r_out keeps the previous result until ACK.
                r_res_next = per_d_out;
                state_next = RD_Q;
            end
            RD_Q:  state_next = Q_CAP;
            Q_CAP: begin
                q_out_next = per_d_out;
                r_out_next = r_res_reg;
                err_next   = 1'b0;
                state_next = ACK;
            end
            ACK: begin
                ptr_next   = gnt_id_reg;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            WR_RR: begin
                cs_next   = 1'b1;
                wr_next   = 1'b1;
                addr_next = ADDR_RR;
                d_in_next = rad_next;
            end
            WR_INIT1: begin
                cs_next   = 1'b1;
                wr_next   = 1'b1;
                addr_next = ADDR_INIT;
                d_in_next = 16'h0001;
            end
            WR_INIT0: begin
                cs_next   = 1'b1;
                wr_next   = 1'b1;
                addr_next = ADDR_INIT;
            end
            POLL_RD: begin
                cs_next   = 1'b1;
                rd_next   = 1'b1;
                addr_next = ADDR_DONE;
            end
            RD_R: begin
                cs_next   = 1'b1;
                rd_next   = 1'b1;
                addr_next = ADDR_R;
            end
            RD_Q: begin
                cs_next   = 1'b1;
                rd_next   = 1'b1;
                addr_next = ADDR_Q;
            end
            ACK:     ack_next = N_REQ'(1) << gnt_id_next;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            rad_reg    <= '0;
            poll_reg   <= '0;
            r_res_reg  <= '0;
            gnt_id_reg <= '0;
            busy_reg   <= 1'b0;
            ack_reg    <= '0;
            err_reg    <= 1'b0;
            q_out_reg  <= '0;
            r_out_reg  <= '0;
            cs_reg     <= 1'b0;
            rd_reg     <= 1'b0;
            wr_reg     <= 1'b0;
            addr_reg   <= '0;
            d_in_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            rad_reg    <= rad_next;
            poll_reg   <= poll_next;
            r_res_reg  <= r_res_next;
            gnt_id_reg <= gnt_id_next;
            busy_reg   <= busy_next;
            ack_reg    <= ack_next;
            err_reg    <= err_next;
            q_out_reg  <= q_out_next;
            r_out_reg  <= r_out_next;
            cs_reg     <= cs_next;
            rd_reg     <= rd_next;
            wr_reg     <= wr_next;
            addr_reg   <= addr_next;
            d_in_reg   <= d_in_next;
        end
    end

    assign ack      = ack_reg;
    assign err      = err_reg;
    assign q_out    = q_out_reg;
    assign r_out    = r_out_reg;
    assign busy     = busy_reg;
    assign gnt_id   = gnt_id_reg;
    assign per_cs   = cs_reg;
    assign per_rd   = rd_reg;
    assign per_wr   = wr_reg;
    assign per_addr = addr_reg;
    assign per_d_in = d_in_reg;

endmodule

// File: tb/tb_raiz_sched.sv
// Directed testbench for raiz_sched with a behavioural raiz peripheral.
module tb_raiz_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] radicand;
    logic [1:0]  ack;
    logic        err;
    logic [15:0] q_out;
    logic [15:0] r_out;
    logic        busy;
    logic [1:0]  gnt_id;
    logic        per_cs;
    logic        per_rd;
    logic        per_wr;
    logic [4:0]  per_addr;
    logic [15:0] per_d_in;
    logic [15:0] per_d_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    raiz_sched #(
        .N_REQ(2),
        .POLL_MAX(16'd4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .radicand(radicand),
        .ack(ack),
        .err(err),
        .q_out(q_out),
        .r_out(r_out),
        .busy(busy),
        .gnt_id(gnt_id),
        .per_cs(per_cs),
        .per_rd(per_rd),
        .per_wr(per_wr),
        .per_addr(per_addr),
        .per_d_in(per_d_in),
        .per_d_out(per_d_out)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- peripheral model ----------------
    logic [15:0] m_rr       = 16'h0000;
    int          m_polls    = 0;
    int          done_after = 1;
    bit          never_done = 1'b0;

    function automatic logic [15:0] isqrt(input logic [15:0] x);
        int q = 0;
        while ((q + 1) * (q + 1) <= int'(x)) q++;
        return 16'(q);
    endfunction

    always @(posedge clk) begin
        per_d_out <= 16'hBEEE;
        if (per_cs && per_wr) begin
            if (per_addr == 5'h04) m_rr <= per_d_in;
            if (per_addr == 5'h08) m_polls <= 0;
        end
        if (per_cs && per_rd) begin
            case (per_addr)
                5'h14: begin
                    m_polls   <= m_polls + 1;
                    per_d_out <= (!never_done && (m_polls + 1 >= done_after)) ? 16'h0001 : 16'h0000;
                end
                5'h0C:   per_d_out <= m_rr - isqrt(m_rr) * isqrt(m_rr);
                5'h10:   per_d_out <= isqrt(m_rr);
                default: per_d_out <= 16'hBEEE;
            endcase
        end
    end

    // ---------------- bus monitor ----------------
    logic [22:0] bus_log[$];
    int          wrrr_cyc  = 0;
    int          idle_viol = 0;

    always @(negedge clk) begin
        if (per_cs)
            bus_log.push_back({per_wr, per_rd, per_addr, (per_wr ? per_d_in : 16'h0000)});
        if (per_cs && per_wr && per_addr == 5'h04)
            wrrr_cyc = cyc;
        if (!per_cs && (per_rd || per_wr || per_addr != 5'h00 || per_d_in != 16'h0000))
            idle_viol++;
    end

    function automatic int count_polls(input int start);
        int n = 0;
        for (int i = start; i < bus_log.size(); i++)
            if (bus_log[i][20:16] == 5'h14) n++;
        return n;
    endfunction

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            if (ack !== 2'b00) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b00;
        radicand = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ack, err, q_out, r_out, busy, gnt_id} !== 38'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ack=%b err=%b q=%h r=%h busy=%b gnt=%0d want all 0",
                     ack, err, q_out, r_out, busy, gnt_id);
        end
        n_cmp++;
        if ({per_cs, per_rd, per_wr, per_addr, per_d_in} !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got cs=%b rd=%b wr=%b addr=%h din=%h want all 0",
                     per_cs, per_rd, per_wr, per_addr, per_d_in);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_single();
        bit ok;
        int s0;
        int v0;
        logic [22:0] exp_tab [8];
        logic [22:0] got;
        exp_tab[0] = {1'b1, 1'b0, 5'h04, 16'h0310};
        exp_tab[1] = {1'b1, 1'b0, 5'h08, 16'h0001};
        exp_tab[2] = {1'b1, 1'b0, 5'h08, 16'h0000};
        exp_tab[3] = {1'b0, 1'b1, 5'h14, 16'h0000};
        exp_tab[4] = {1'b0, 1'b1, 5'h14, 16'h0000};
        exp_tab[5] = {1'b0, 1'b1, 5'h14, 16'h0000};
        exp_tab[6] = {1'b0, 1'b1, 5'h0C, 16'h0000};
        exp_tab[7] = {1'b0, 1'b1, 5'h10, 16'h0000};
        never_done = 1'b0;
        done_after = 3;
        s0 = bus_log.size();
        v0 = idle_viol;
        radicand[15:0] = 16'h0310;
        req = 2'b01;
        wait_ack(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL single_ack_timeout: got no ack want ack"); end
        n_cmp++;
        if (ack !== 2'b01) begin n_bad++; $display("FAIL single_ack: got %b want 01", ack); end
        n_cmp++;
        if (q_out !== 16'h001C) begin n_bad++; $display("FAIL single_q: got %h want 001c", q_out); end
        n_cmp++;
        if (r_out !== 16'h0000) begin n_bad++; $display("FAIL single_r: got %h want 0000", r_out); end
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", err); end
        n_cmp++;
        if (busy !== 1'b1 || gnt_id !== 2'd0) begin
            n_bad++; $display("FAIL single_busy_gnt: got busy=%b gnt=%0d want 1/0", busy, gnt_id);
        end
        n_cmp++;
        if (cyc - wrrr_cyc != 13) begin
            n_bad++; $display("FAIL single_latency: got %0d want 13", cyc - wrrr_cyc);
        end
        req = 2'b00;
        @(posedge clk); #1;
        n_cmp++;
        if (ack !== 2'b00 || busy !== 1'b0) begin
            n_bad++; $display("FAIL single_after_ack: got ack=%b busy=%b want 00/0", ack, busy);
        end
        n_cmp++;
        if (bus_log.size() - s0 != 8) begin
            n_bad++; $display("FAIL single_bus_count: got %0d want 8", bus_log.size() - s0);
        end
        for (int i = 0; i < 8; i++) begin
            got = (s0 + i < bus_log.size()) ? bus_log[s0 + i] : 23'h7FFFFF;
            n_cmp++;
            if (got !== exp_tab[i]) begin
                n_bad++; $display("FAIL single_bus_%0d: got %h want %h", i, got, exp_tab[i]);
            end
        end
        n_cmp++;
        if (idle_viol != v0) begin
            n_bad++; $display("FAIL single_bus_idle: got %0d violations want 0", idle_viol - v0);
        end
        $display("test_single: ack=%b q=%h r=%h err=%b", ack, q_out, r_out, err);
    endtask

    task automatic test_two_simul();
        bit ok;
        do_reset();
        never_done = 1'b0;
        done_after = 1;
        radicand = {16'd50, 16'd100};
        req = 2'b11;
        wait_ack(ok);
        n_cmp++;
        if (!ok || ack !== 2'b10 || gnt_id !== 2'd1) begin
            n_bad++; $display("FAIL two_first_ack: got ok=%b ack=%b gnt=%0d want 1/10/1", ok, ack, gnt_id);
        end
        n_cmp++;
        if (q_out !== 16'd7 || r_out !== 16'd1 || err !== 1'b0) begin
            n_bad++; $display("FAIL two_first_res: got q=%0d r=%0d err=%b want 7/1/0", q_out, r_out, err);
        end
        req[1] = 1'b0;
        wait_ack(ok);
        n_cmp++;
        if (!ok || ack !== 2'b01) begin
            n_bad++; $display("FAIL two_second_ack: got ok=%b ack=%b want 1/01", ok, ack);
        end
        n_cmp++;
        if (q_out !== 16'd10 || r_out !== 16'd0) begin
            n_bad++; $display("FAIL two_second_res: got q=%0d r=%0d want 10/0", q_out, r_out);
        end
        n_cmp++;
        if (cyc - wrrr_cyc != 9) begin
            n_bad++; $display("FAIL two_latency: got %0d want 9", cyc - wrrr_cyc);
        end
        req[0] = 1'b0;
        $display("test_two_simul: q=%0d r=%0d", q_out, r_out);
    endtask

    task automatic test_fair();
        bit ok;
        radicand = {16'd144, 16'd81};
        req = 2'b11;
        wait_ack(ok);
        n_cmp++;
        if (!ok || ack !== 2'b10 || q_out !== 16'd12) begin
            n_bad++; $display("FAIL fair_first: got ok=%b ack=%b q=%0d want 1/10/12", ok, ack, q_out);
        end
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if (busy !== 1'b1 || gnt_id !== 2'd0) begin
            n_bad++; $display("FAIL fair_regrant: got busy=%b gnt=%0d want 1/0", busy, gnt_id);
        end
        req[1] = 1'b0;
        wait_ack(ok);
        n_cmp++;
        if (!ok || ack !== 2'b01 || q_out !== 16'd9 || r_out !== 16'd0) begin
            n_bad++; $display("FAIL fair_second: got ok=%b ack=%b q=%0d r=%0d want 1/01/9/0", ok, ack, q_out, r_out);
        end
        req[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL fair_idle: got busy=%b want 0", busy); end
        $display("test_fair: second ack served requester 0");
    endtask

    task automatic test_timeout();
        bit ok;
        int s0;
        never_done = 1'b1;
        s0 = bus_log.size();
        radicand[15:0] = 16'd4;
        req = 2'b01;
        wait_ack(ok);
        n_cmp++;
        if (!ok || ack !== 2'b01 || err !== 1'b1) begin
            n_bad++; $display("FAIL timeout_ack: got ok=%b ack=%b err=%b want 1/01/1", ok, ack, err);
        end
        n_cmp++;
        if (q_out !== 16'hFFFF || r_out !== 16'hFFFF) begin
            n_bad++; $display("FAIL timeout_res: got q=%h r=%h want ffff/ffff", q_out, r_out);
        end
        n_cmp++;
        if (count_polls(s0) != 4) begin
            n_bad++; $display("FAIL timeout_polls: got %0d want 4", count_polls(s0));
        end
        n_cmp++;
        if (cyc - wrrr_cyc != 11) begin
            n_bad++; $display("FAIL timeout_latency: got %0d want 11", cyc - wrrr_cyc);
        end
        req = 2'b00;
        @(posedge clk); #1;
        never_done = 1'b0;
        done_after = 2;
        radicand[15:0] = 16'd1000;
        req = 2'b01;
        wait_ack(ok);
        n_cmp++;
        if (!ok || ack !== 2'b01 || err !== 1'b0 || q_out !== 16'd31 || r_out !== 16'd39) begin
            n_bad++; $display("FAIL timeout_recover: got ok=%b ack=%b err=%b q=%0d r=%0d want 1/01/0/31/39",
                              ok, ack, err, q_out, r_out);
        end
        n_cmp++;
        if (cyc - wrrr_cyc != 11) begin
            n_bad++; $display("FAIL recover_latency: got %0d want 11", cyc - wrrr_cyc);
        end
        req = 2'b00;
        $display("test_timeout: recovered q=%0d r=%0d", q_out, r_out);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        int acks = 0;
        never_done = 1'b1;
        radicand[15:0] = 16'hABCD;
        req = 2'b01;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (per_cs && per_rd && per_addr == 5'h14) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL rstmid_poll: got no done poll want poll"); end
        rst = 1'b1;
        req = 2'b00;
        @(posedge clk); #1;
        n_cmp++;
        if ({ack, err, busy, gnt_id, per_cs, per_rd, per_wr, per_addr, per_d_in} !== 30'h0 ||
            q_out !== 16'h0 || r_out !== 16'h0) begin
            n_bad++; $display("FAIL rstmid_outputs: got ack=%b err=%b busy=%b gnt=%0d cs=%b rd=%b addr=%h q=%h r=%h want all 0",
                              ack, err, busy, gnt_id, per_cs, per_rd, per_addr, q_out, r_out);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ack !== 2'b00 || busy !== 1'b0) acks++;
        end
        n_cmp++;
        if (acks != 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", acks); end
        never_done = 1'b0;
        done_after = 1;
        radicand[31:16] = 16'd225;
        req = 2'b10;
        wait_ack(ok);
        n_cmp++;
        if (!ok || ack !== 2'b10 || q_out !== 16'd15 || r_out !== 16'd0 || err !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_next: got ok=%b ack=%b q=%0d r=%0d err=%b want 1/10/15/0/0",
                              ok, ack, q_out, r_out, err);
        end
        n_cmp++;
        if (cyc - wrrr_cyc != 9) begin
            n_bad++; $display("FAIL rstmid_latency: got %0d want 9", cyc - wrrr_cyc);
        end
        req = 2'b00;
        $display("test_reset_mid: next request q=%0d", q_out);
    endtask

    task automatic test_latch();
        bit ok;
        bit granted = 1'b0;
        int s0;
        logic [22:0] got;
        done_after = 1;
        s0 = bus_log.size();
        radicand[15:0] = 16'h0040;
        req = 2'b01;
        for (int i = 0; i < 20 && !granted; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b1) granted = 1'b1;
        end
        radicand[15:0] = 16'h1234;
        wait_ack(ok);
        got = (s0 < bus_log.size()) ? bus_log[s0] : 23'h7FFFFF;
        n_cmp++;
        if (got !== {1'b1, 1'b0, 5'h04, 16'h0040}) begin
            n_bad++; $display("FAIL latch_wr_rr: got %h want %h", got, {1'b1, 1'b0, 5'h04, 16'h0040});
        end
        n_cmp++;
        if (!ok || ack !== 2'b01 || q_out !== 16'd8 || r_out !== 16'd0) begin
            n_bad++; $display("FAIL latch_res: got ok=%b ack=%b q=%0d r=%0d want 1/01/8/0", ok, ack, q_out, r_out);
        end
        req = 2'b00;
        $display("test_latch: q=%0d r=%0d", q_out, r_out);
    endtask

    initial begin
        rst = 1'b1;
        req = 2'b00;
        radicand = 32'h0;
        test_reset();
        test_single();
        test_two_simul();
        test_fair();
        test_timeout();
        test_reset_mid();
        test_latch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
